din_debounce: RTL and testbench



---
 rtl/din_debounce_pkg.sv | 5 +
 rtl/din_debounce_sync.sv | 17 +
 rtl/din_debounce.sv | 55 +++++
 tb/tb_din_debounce.sv | 122 ++++++++++++
 4 files changed

// File: rtl/din_debounce_pkg.sv
// din_debounce_pkg: shared FSM state encoding and synchronizer depth for din_debounce
package din_debounce_pkg;
  typedef enum logic [1:0] {ST_LO, ST_CHK_HI, ST_HI, ST_CHK_LO} db_state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/din_debounce_sync.sv
// sync_2ff: reset-preloaded flop chain bringing an asynchronous level into the clk domain
module sync_2ff
  import din_debounce_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= {SYNC_STAGES{RST_VAL}};
    else ff <= {ff[SYNC_STAGES-2:0], d};
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/din_debounce.sv
// din_debounce: filters a bouncy level into a clean registered dout plus a one-cycle chg strobe
// Define DIN_DEBOUNCE_SYNC_EN to put a 2-FF synchronizer in front of the FSM.
module din_debounce
  import din_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic dout,
  output logic chg
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam bit ONE = (STABLE_CYCLES == 1);
  if (STABLE_CYCLES < 1) begin : g_bad_cycles
    $error("din_debounce: STABLE_CYCLES must be at least 1");
  end
  logic s, done, dout_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  db_state_t state, st_nxt;
`ifdef DIN_DEBOUNCE_SYNC_EN
  sync_2ff #(.RST_VAL(RST_VAL)) u_sync (.clk(clk), .rst(rst), .d(din_raw), .q(s));
`else
  assign s = din_raw;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RST_VAL ? ST_HI : ST_LO;
      cnt   <= '0;
      dout  <= RST_VAL;
      chg   <= 1'b0;
    end else begin
      state <= st_nxt;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
      chg   <= dout_nxt != dout;
    end
  // a revert in a CHK state beats a completing count on the same edge
  always_comb begin
    done = cnt == LAST;
    case (state)
      ST_LO:     st_nxt = s ? (ONE ? ST_HI : ST_CHK_HI) : ST_LO;
      ST_CHK_HI: st_nxt = !s ? ST_LO : done ? ST_HI : ST_CHK_HI;
      ST_HI:     st_nxt = !s ? (ONE ? ST_LO : ST_CHK_LO) : ST_HI;
      default:   st_nxt = s ? ST_HI : done ? ST_LO : ST_CHK_LO;
    endcase
  end
  always_comb begin
    cnt_nxt  = (st_nxt == ST_CHK_HI || st_nxt == ST_CHK_LO) ? cnt + 1'b1 : '0;
    dout_nxt = st_nxt == ST_HI || st_nxt == ST_CHK_LO;
  end
endmodule

// File: tb/tb_din_debounce.sv
// tb_din_debounce: history-model scoreboard plus segment table for din_debounce
module tb_din_debounce;
  localparam int N = 4;
`ifdef DIN_DEBOUNCE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam int LAT = SYNC ? N + 1 : N - 1;
  localparam int D1 = SYNC ? 2 : 0;
  typedef struct packed {logic dout; logic chg;} exp_t;
  typedef struct {logic din; int len; logic d; int at;} vec_t;
  logic clk = 1'b0, rst = 1'b1, din_raw = 1'b0, din1 = 1'b0;
  logic dout, chg, dout1, chg1;
  logic p1, p2, m_dout;
  logic [N-1:0] hist;
  exp_t q[$];
  vec_t tbl[$];
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  din_debounce #(.STABLE_CYCLES(N), .RST_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .din_raw(din_raw), .dout(dout), .chg(chg));
  din_debounce #(.STABLE_CYCLES(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din_raw(din1), .dout(dout1), .chg(chg1));
  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask
  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic model_reset;
    p1 = 1'b0; p2 = 1'b0; m_dout = 1'b0; hist = '0; q.delete();
  endtask
  // dout toggles once the last N samples all carry the opposite level
  task automatic step(input logic v, input logic v1);
    logic s;
    exp_t e;
    @(negedge clk);
    din_raw = v; din1 = v1;
    s = SYNC ? p2 : v;
    p2 = p1; p1 = v;
    hist = {hist[N-2:0], s};
    e.chg = hist == {N{~m_dout}};
    if (e.chg) m_dout = ~m_dout;
    e.dout = m_dout;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    check("dout", dout, e.dout);
    check("chg", chg, e.chg);
  endtask
  task automatic do_reset(input logic din_hold);
    din_raw = din_hold; din1 = 1'b0; rst = 1'b1;
    #1;
    check("rst_async_dout", dout, 1'b0);
    check("rst_async_chg", chg, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_dout", dout, 1'b0);
      check("rst_chg", chg, 1'b0);
      check("rst_dout1", dout1, 1'b0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    int first, n;
    tbl.push_back('{1'b1, 8, 1'b1, LAT});
    tbl.push_back('{1'b0, 10, 1'b0, LAT});
    tbl.push_back('{1'b1, 3, 1'b0, -1});
    tbl.push_back('{1'b0, 8, 1'b0, -1});
    tbl.push_back('{1'b1, 1, 1'b0, -1});
    tbl.push_back('{1'b0, 1, 1'b0, -1});
    tbl.push_back('{1'b1, 1, 1'b0, -1});
    tbl.push_back('{1'b0, 1, 1'b0, -1});
    tbl.push_back('{1'b1, 12, 1'b1, LAT});
    tbl.push_back('{1'b0, 2, 1'b1, -1});
    tbl.push_back('{1'b1, 8, 1'b1, -1});
    tbl.push_back('{1'b0, 3, 1'b1, -1});
    tbl.push_back('{1'b1, 8, 1'b1, -1});
    tbl.push_back('{1'b0, 10, 1'b0, LAT});
    tbl.push_back('{1'b1, 3, 1'b0, -1});
    tbl.push_back('{1'b0, 9, 1'b0, -1});
    do_reset(1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      first = -1; n = 0;
      for (int k = 0; k < tbl[i].len; k++) begin
        step(tbl[i].din, 1'b0);
        if (chg === 1'b1) begin
          n++;
          if (first < 0) first = k;
        end
      end
      check_int($sformatf("seg%0d_chg_at", i), first, tbl[i].at);
      check_int($sformatf("seg%0d_chg_n", i), n, tbl[i].at < 0 ? 0 : 1);
      check($sformatf("seg%0d_dout", i), dout, tbl[i].d);
    end
    repeat (SYNC ? 4 : 2) step(1'b1, 1'b0);
    do_reset(1'b1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0);
      if (chg !== 1'b0) n++;
    end
    check_int("midcount_no_chg", n, 0);
    repeat (10) step(1'b1, 1'b0);
    check("high_before_rst", dout, 1'b1);
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, k == 0);
      check($sformatf("n1_dout_%0d", k), dout1, k == D1);
      check($sformatf("n1_chg_%0d", k), chg1, k == D1 || k == D1 + 1);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
